fetch_unit: RTL

- Instruction fetch stage for the TinyCPU core.
- Holds the program counter (PC) and issues one instruction-memory read at a time over a valid/ready request channel.
- Captures the response and presents it, tagged with its PC, to the decode stage over a valid/ready output channel.
- Accepts a branch/jump redirect from execute at any time.

---
 rtl/fetch_unit_pkg.sv | 15 +
 rtl/fetch_unit_pc_reg.sv | 22 ++
 rtl/fetch_unit.sv | 117 +++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the TinyCPU fetch stage: default bus widths and
// the fetch FSM state encoding.
package fetch_unit_pkg;

    localparam int FETCH_ADDR_W  = 8;
    localparam int FETCH_INSTR_W = 16;

    typedef enum logic [1:0] {
        FETCH_REQ   = 2'd0,  // request presented at current PC
        FETCH_WAIT  = 2'd1,  // request accepted, waiting for data
        FETCH_HOLD  = 2'd2,  // instruction held for decode
        FETCH_DRAIN = 2'd3   // swallow one stale response
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: sync reset to RESET_PC, load beats increment,
// increment wraps modulo 2^ADDR_W.
module pc_reg #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] load_pc,
    output logic [ADDR_W-1:0] pc
);

    // PC update: reset, then redirect load, then sequential increment
    always_ff @(posedge clk) begin
        if (rst)       pc <= RESET_PC;
        else if (load) pc <= load_pc;
        else if (inc)  pc <= pc + ADDR_W'(1);
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding instruction-memory read, the
// result registered and handed to decode. Redirects are accepted at any
// time; a response belonging to an abandoned request is drained.
// Optional build macro: FETCH_PERF_EN adds a 32-bit delivered-instruction
// counter on port fetch_count.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = FETCH_ADDR_W,
    parameter int                INSTR_W  = FETCH_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_resp_valid,
    input  logic [INSTR_W-1:0] mem_resp_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc
`ifdef FETCH_PERF_EN
   ,output logic [31:0]        fetch_count
`endif
);

    fetch_state_e      state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic              take_resp;

    // A response is kept only when it answers a live request and no
    // redirect lands on the same edge.
    assign take_resp = (state == FETCH_WAIT) && mem_resp_valid && !redirect_valid;
    assign mem_addr  = pc;

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk     (clk),
        .rst     (rst),
        .load    (redirect_valid),
        .inc     (take_resp),
        .load_pc (redirect_pc),
        .pc      (pc)
    );

    // State register
    always_ff @(posedge clk) begin
        state <= state_nxt;
    end

    // Next state and request strobe; reset overrides everything but still
    // remembers whether a response is in flight and must be discarded.
    always_comb begin
        state_nxt     = state;
        mem_req_valid = (state == FETCH_REQ) && !rst;
        case (state)
            FETCH_REQ: begin
                if (mem_req_ready)
                    state_nxt = redirect_valid ? FETCH_DRAIN : FETCH_WAIT;
            end
            FETCH_WAIT: begin
                if (redirect_valid)
                    state_nxt = mem_resp_valid ? FETCH_REQ : FETCH_DRAIN;
                else if (mem_resp_valid)
                    state_nxt = FETCH_HOLD;
            end
            FETCH_HOLD: begin
                if (redirect_valid || instr_ready)
                    state_nxt = FETCH_REQ;
            end
            FETCH_DRAIN: begin
                if (mem_resp_valid)
                    state_nxt = FETCH_REQ;
            end
            default: state_nxt = FETCH_REQ;
        endcase
        if (rst)
            state_nxt = ((state == FETCH_WAIT || state == FETCH_DRAIN) && !mem_resp_valid)
                        ? FETCH_DRAIN : FETCH_REQ;
    end

    // Decode-facing output register: capture on response, clear on
    // consume or redirect (redirect drops a held instruction outright)
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_valid <= 1'b0;
            instr_data  <= '0;
            instr_pc    <= '0;
        end else if (redirect_valid) begin
            instr_valid <= 1'b0;
        end else if (take_resp) begin
            instr_valid <= 1'b1;
            instr_data  <= mem_resp_data;
            instr_pc    <= pc;
        end else if (state == FETCH_HOLD && instr_ready) begin
            instr_valid <= 1'b0;
        end
    end

`ifdef FETCH_PERF_EN
    // Delivered-instruction counter; a redirect on the consume edge means
    // the instruction was dropped, not delivered
    always_ff @(posedge clk) begin
        if (rst)
            fetch_count <= '0;
        else if (instr_valid && instr_ready && !redirect_valid)
            fetch_count <= fetch_count + 32'd1;
    end
`endif

endmodule
